// File: rtl/apb4_archinfo_ext_pkg.sv
// Shared definitions for the architecture-info slave: word map, CTRL bit
// positions, lock FSM states and a byte-strobe merge helper.
package archinfo_pkg;

  localparam int unsigned IDX_SYS  = 0;
  localparam int unsigned IDX_IDL  = 1;
  localparam int unsigned IDX_IDH  = 2;
  localparam int unsigned IDX_CTRL = 3;
  localparam int unsigned IDX_KEY  = 4;
  localparam int unsigned IDX_UPTL = 5;
  localparam int unsigned IDX_UPTH = 6;
  localparam int unsigned IDX_SCR0 = 7;

  localparam int unsigned CTRL_LOCK = 0;
  localparam int unsigned CTRL_EN   = 1;
  localparam int unsigned CTRL_CLR  = 2;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    KEY1     = 2'd1,
    UNLOCKED = 2'd2
  } lock_state_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/apb4_archinfo_ext_if.sv
// APB4 completer-side bus bundle; clock and reset stay outside.
interface apb4_archinfo_ext_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [2:0]        pprot;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
                  input  prdata, pready, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb4_archinfo_ext_lock_fsm.sv
// Two-word key unlock sequencer guarding the identity registers.
module archinfo_lock_fsm
  import archinfo_pkg::*;
#(
  parameter logic [31:0] KEY_A = 32'h5A5A_A5A5,
  parameter logic [31:0] KEY_B = 32'hC3C3_3C3C
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        key_wr_i,
  input  logic [31:0] key_data_i,
  output logic        unlocked_o
);

  lock_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= LOCKED;
    else       state_q <= state_d;
  end

  // Only KEY writes move the machine; any wrong word falls back to LOCKED.
  always_comb begin
    state_d = state_q;
    if (key_wr_i) begin
      case (state_q)
        LOCKED:  if (key_data_i == KEY_A) state_d = KEY1;
        KEY1:    state_d = (key_data_i == KEY_B) ? UNLOCKED : LOCKED;
        default: state_d = LOCKED;
      endcase
    end
  end

  assign unlocked_o = (state_q == UNLOCKED);

endmodule

// File: rtl/apb4_archinfo_ext.sv
// APB4 architecture-info slave: identity regs, scratch regs, 64-bit uptime
// counter with coherent high-word snapshot, key-guarded identity writes.
module apb4_archinfo_ext
  import archinfo_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter logic [31:0] SYS_VAL = 32'h0000_0000,
  parameter logic [31:0] IDL_VAL = 32'h0000_0000,
  parameter logic [31:0] IDH_VAL = 32'h0000_0000,
  parameter int unsigned NUM_SCR = 4,
  parameter logic [31:0] KEY_A   = 32'h5A5A_A5A5,
  parameter logic [31:0] KEY_B   = 32'hC3C3_3C3C
) (
  input  logic                pclk,
  input  logic                preset,
  apb4_archinfo_ext_if.slave  apb
);

  localparam int unsigned IW = ADDR_W - 2;
  localparam logic [IW-1:0] I_SYS  = IW'(IDX_SYS);
  localparam logic [IW-1:0] I_IDL  = IW'(IDX_IDL);
  localparam logic [IW-1:0] I_IDH  = IW'(IDX_IDH);
  localparam logic [IW-1:0] I_CTRL = IW'(IDX_CTRL);
  localparam logic [IW-1:0] I_KEY  = IW'(IDX_KEY);
  localparam logic [IW-1:0] I_UPTL = IW'(IDX_UPTL);
  localparam logic [IW-1:0] I_UPTH = IW'(IDX_UPTH);
  localparam logic [IW-1:0] I_END  = IW'(IDX_SCR0 + NUM_SCR);

  logic [IW-1:0] idx;
  logic          access, wr, rd, in_map, is_id, unlocked;
  logic          ctrl_wr, cnt_clr, id_wr, err;
  logic [31:0]   rdata;

  logic [31:0]               sys_q, idl_q, idh_q, snap_q;
  logic                      cnt_en_q;
  logic [63:0]               cnt_q, cnt_d;
  logic [NUM_SCR-1:0][31:0]  scr_q;

  logic unused_apb;
  assign unused_apb = ^{apb.pprot, apb.paddr[1:0]};

  assign idx     = apb.paddr[ADDR_W-1:2];
  assign access  = apb.psel & apb.penable;
  assign wr      = access &  apb.pwrite;
  assign rd      = access & ~apb.pwrite;
  assign in_map  = (idx < I_END);
  assign is_id   = (idx == I_SYS) || (idx == I_IDL) || (idx == I_IDH);
  assign ctrl_wr = wr && (idx == I_CTRL) && apb.pstrb[0];
  assign cnt_clr = ctrl_wr && apb.pwdata[CTRL_CLR];
  assign id_wr   = wr && unlocked;

  archinfo_lock_fsm #(.KEY_A(KEY_A), .KEY_B(KEY_B)) u_lock (
    .clk_i      (pclk),
    .rst_i      (preset),
    .key_wr_i   (wr && (idx == I_KEY)),
    .key_data_i (apb.pwdata),
    .unlocked_o (unlocked)
  );

  // Clear wins over increment; the count wraps naturally at 2^64.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)       cnt_d = '0;
    else if (cnt_en_q) cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      sys_q    <= SYS_VAL;
      idl_q    <= IDL_VAL;
      idh_q    <= IDH_VAL;
      cnt_en_q <= 1'b1;
      cnt_q    <= '0;
      snap_q   <= '0;
      scr_q    <= '0;
    end else begin
      if (id_wr && idx == I_SYS) sys_q <= strb_merge(sys_q, apb.pwdata, apb.pstrb);
      if (id_wr && idx == I_IDL) idl_q <= strb_merge(idl_q, apb.pwdata, apb.pstrb);
      if (id_wr && idx == I_IDH) idh_q <= strb_merge(idh_q, apb.pwdata, apb.pstrb);
      if (ctrl_wr) cnt_en_q <= apb.pwdata[CTRL_EN];
      cnt_q <= cnt_d;
      // High word is frozen at the UPTL read so a later UPTH read is coherent.
      if (rd && idx == I_UPTL) snap_q <= cnt_q[63:32];
      for (int i = 0; i < NUM_SCR; i++)
        if (wr && idx == IW'(IDX_SCR0 + i))
          scr_q[i] <= strb_merge(scr_q[i], apb.pwdata, apb.pstrb);
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      I_SYS:  rdata = sys_q;
      I_IDL:  rdata = idl_q;
      I_IDH:  rdata = idh_q;
      I_CTRL: begin
        rdata[CTRL_LOCK] = ~unlocked;
        rdata[CTRL_EN]   = cnt_en_q;
      end
      I_KEY:  rdata = '0;
      I_UPTL: rdata = cnt_q[31:0];
      I_UPTH: rdata = snap_q;
      default: begin
        for (int i = 0; i < NUM_SCR; i++)
          if (idx == IW'(IDX_SCR0 + i)) rdata = scr_q[i];
      end
    endcase
  end

  always_comb begin
    err = 1'b0;
    if (access) begin
      if (!in_map)                                              err = 1'b1;
      else if (apb.pwrite && (idx == I_UPTL || idx == I_UPTH))  err = 1'b1;
      else if (apb.pwrite && is_id && !unlocked)                err = 1'b1;
    end
  end

  assign apb.prdata  = rd ? rdata : '0;
  assign apb.pslverr = err;
  assign apb.pready  = 1'b1;

endmodule
